riscv_nn_qnt_packer: RTL and testbench
======================================

// Module: riscv_nn_qnt_packer
// PURPOSE
//  Downstream of the threshold-tree quantization unit. Collects its per-instruction results (two
//  pixels of 4-bit or 2-bit codes) and packs them LSB-first into full OUT_W-bit words for the
//  store path. Holds one word in assembly and one in an output slot, so quantization does not stall
//  while a packed word waits. Flushes partial words at tile end or when the mode changes.
// PARAMETERS
//  OUT_W  32  packed word width; must be a multiple of 8. CAP4 = OUT_W/8, CAP2 = OUT_W/4 elements.
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      reset, asynchronous, active-low
//  clear_i       in   1      synchronous clear; drops the acc word, the out word and a pending flush
//  vecmode_i     in   3      VEC_MODE2 = 2-bit codes; any other value = 4-bit codes
//  in_valid_i    in   1      quantized result available
//  in_data_i     in   8      4-bit mode: {pix2[3:0],pix1[3:0]}; 2-bit mode: [3:0]={pix2,pix1}, [7:4] ignored
//  in_ready_o    out  1      element accepted when in_valid_i & in_ready_o
//  flush_i       in   1      single-cycle pulse: emit the partial word
//  flush_done_o  out  1      1-cycle pulse: flush completed
//  out_valid_o   out  1      packed word valid
//  out_ready_i   in   1      consumer takes word when out_valid_o & out_ready_i
//  out_data_o    out  OUT_W  packed word; unused slots zero
//  out_count_o   out  4      elements in the word (1..CAP)
//  out_last_o    out  1      word was emitted by a flush or a mode switch (partial/terminal)
// BEHAVIOUR
//  - Reset/clear: all outputs 0 except in_ready_o=1. acc=0, fill=0, flush_pend=0.
//    Reset mid-word drops data with no emit.
//  - State: acc[OUT_W], fill (0..CAP2), acc_mode (latched on the element written at fill==0),
//    out reg, out_count reg, out_last reg, out_valid reg, flush_pend reg.
//  - out_free = !out_valid_o | out_ready_i. A word moves into the out reg only when out_free.
//    out_valid_o rises the cycle after the move.
//  - Slot placement: 4-bit mode: element k goes to acc[8k+7:8k]. 2-bit mode: element k goes to acc[4k+3:4k].
//  - Accept cases, where cap = CAP of acc_mode (or of vecmode_i when fill==0):
//    a) Normal: fill+1 < cap and the mode matches, or fill==0. Write the slot and fill++.
//       in_ready_o=1 always.
//    b) Complete: fill+1 == cap. Needs out_free. out <= acc | element, count=cap, last=0;
//       acc <= 0; fill <= 0.
//    c) Mode switch: fill>0 and the mode differs. Needs out_free. out <= acc, count=fill, last=1.
//       The element goes to slot 0 of a fresh acc, fill <= 1, acc_mode <= new mode.
//       Both happen in one cycle.
//    In cases b and c, in_ready_o = out_free. The out_free term is combinational on out_ready_i.
//  - Flush: flush_i sets flush_pend. While flush_pend=1, in_ready_o=0.
//    - If fill==0: clear flush_pend and pulse flush_done_o on the next cycle.
//    - Else, when out_free: out <= acc, count=fill, last=1, fill <= 0, clear flush_pend, pulse
//      flush_done_o in the same cycle that out_valid_o rises.
//    - flush_i coincident with an accepted element: the element is taken first and included in the
//      flush. If that element completes the word, it is a normal emit (last=0) and the flush finds
//      fill==0.
//    - flush_i while flush_pend=1 is ignored.
//  - The out reg holds stable while out_valid_o & !out_ready_i. On handshake without a new move,
//    out_valid_o falls next cycle.
//  - clear_i has priority over every other event in the same cycle.
//  - Throughput: 1 element/cycle. An out word can be refilled every cycle when out_ready_i=1.
// TESTING
//  1) 4-bit, out_ready=1, feed 0x11,0x22,0x33,0x44 on consecutive cycles ->
//     out 0x44332211, count=4, last=0, valid 1 cycle after the 4th accept.
//  2) 2-bit, feed 0x1..0x8 (upper nibble 0xF) -> out 0x87654321, count=8, upper nibbles never
//     appear in the word.
//  3) 4-bit, out_ready=0, feed 8 elements -> word0 held stable; 4th element of word1 sees
//     in_ready_o=0. Raise out_ready: word0 then 0x88776655 emitted, no element lost.
//  4) 4-bit, feed 0xAB,0xCD, then flush_i -> out 0x0000CDAB, count=2, last=1, flush_done_o pulse.
//     flush_i with fill==0 -> flush_done_o only, no word.
//  5) 4-bit 0x5A, then 2-bit 0x3 -> out 0x0000005A, count=1, last=1. Then 7 more 2-bit 0x3 ->
//     0x33333333, count=8.
//  6) rst_n low after 2 elements -> outputs reset, next 4 4-bit elements form a clean word;
//     same check for clear_i coincident with in_valid_i.

Source files
------------

// File: rtl/riscv_nn_qnt_packer.sv
// Packs 4-bit or 2-bit quantization codes LSB-first into OUT_W-bit words, with one word
// in assembly and one in a skid output slot; flushes partial words on request or mode change.
module riscv_nn_qnt_packer #(
  parameter int unsigned OUT_W     = 32,
  parameter logic [2:0]  VEC_MODE2 = 3'd2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic [2:0]       vecmode_i,
  input  logic             in_valid_i,
  input  logic [7:0]       in_data_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic             flush_done_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic [3:0]       out_count_o,
  output logic             out_last_o
);

  localparam int unsigned CAP4  = OUT_W / 8;
  localparam int unsigned CAP2  = OUT_W / 4;
  localparam int unsigned FillW = $clog2(CAP2 + 1);

  logic [OUT_W-1:0] acc_q, acc_d, out_q, out_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             mode2_q, mode2_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic             pend_q, pend_d;
  logic             done_q, done_d;

  logic             in_mode2, out_free, mode_sw, complete, accept, ready;
  logic [FillW-1:0] cap, fill_inc, slot;
  logic [OUT_W-1:0] elem_word;

  always_comb begin
    in_mode2 = (vecmode_i == VEC_MODE2);
    out_free = !valid_q || out_ready_i;
    // When fill>0 and modes match, the incoming mode equals acc_mode, so one cap serves both.
    cap      = in_mode2 ? FillW'(CAP2) : FillW'(CAP4);
    fill_inc = fill_q + FillW'(1);
    mode_sw  = (fill_q != '0) && (in_mode2 != mode2_q);
    complete = !mode_sw && (fill_inc == cap);
    ready    = !pend_q && (!(mode_sw || complete) || out_free);
    accept   = in_valid_i && ready;
    slot     = mode_sw ? '0 : fill_q;
    if (in_mode2) begin
      elem_word = OUT_W'(in_data_i[3:0]) << {slot, 2'b00};
    end else begin
      elem_word = OUT_W'(in_data_i) << {slot, 3'b000};
    end
  end

  always_comb begin
    acc_d   = acc_q;
    fill_d  = fill_q;
    mode2_d = mode2_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    valid_d = valid_q && !out_ready_i;
    pend_d  = pend_q;
    done_d  = 1'b0;

    if (accept) begin
      if (mode_sw) begin
        out_d   = acc_q;
        cnt_d   = 4'(fill_q);
        last_d  = 1'b1;
        valid_d = 1'b1;
        acc_d   = elem_word;
        fill_d  = FillW'(1);
        mode2_d = in_mode2;
      end else if (complete) begin
        out_d   = acc_q | elem_word;
        cnt_d   = 4'(cap);
        last_d  = 1'b0;
        valid_d = 1'b1;
        acc_d   = '0;
        fill_d  = '0;
        mode2_d = in_mode2;
      end else begin
        acc_d  = acc_q | elem_word;
        fill_d = fill_inc;
        if (fill_q == '0) begin
          mode2_d = in_mode2;
        end
      end
    end else if (pend_q) begin
      if (fill_q == '0) begin
        pend_d = 1'b0;
        done_d = 1'b1;
      end else if (out_free) begin
        out_d   = acc_q;
        cnt_d   = 4'(fill_q);
        last_d  = 1'b1;
        valid_d = 1'b1;
        acc_d   = '0;
        fill_d  = '0;
        pend_d  = 1'b0;
        done_d  = 1'b1;
      end
    end

    if (flush_i && !pend_q) begin
      pend_d = 1'b1;
    end

    if (clear_i) begin
      acc_d   = '0;
      fill_d  = '0;
      mode2_d = 1'b0;
      out_d   = '0;
      cnt_d   = '0;
      last_d  = 1'b0;
      valid_d = 1'b0;
      pend_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      fill_q  <= '0;
      mode2_q <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      mode2_q <= mode2_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  assign in_ready_o   = ready;
  assign flush_done_o = done_q;
  assign out_valid_o  = valid_q;
  assign out_data_o   = out_q;
  assign out_count_o  = cnt_q;
  assign out_last_o   = last_q;

endmodule

// File: tb/tb_riscv_nn_qnt_packer.sv
// Directed bench for riscv_nn_qnt_packer: packing in both modes, backpressure, flush,
// mode switch, reset and clear.
module tb_riscv_nn_qnt_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  vecmode = 3'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_count;
  logic        out_last;

  int checks = 0;
  int failures = 0;

  riscv_nn_qnt_packer #(.OUT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear),
    .vecmode_i   (vecmode),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .flush_i     (flush),
    .flush_done_o(flush_done),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_count_o (out_count),
    .out_last_o  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one element, waiting (bounded) for in_ready; returns 1 ns after the accepting edge.
  task automatic push(input logic [7:0] d, input bit m2);
    in_valid = 1'b1;
    in_data  = d;
    vecmode  = m2 ? 3'd2 : 3'd0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) break;
      tick();
    end
    chk("push_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 10; i++) begin
      if (flush_done) break;
      tick();
    end
    chk("flush_done_seen", flush_done, 1'b1);
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] c,
                          input logic l);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_count"}, out_count, c);
    chk({tag, "_last"}, out_last, l);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_ready"}, in_ready, 1'b1);
    chk({tag, "_done"}, flush_done, 1'b0);
    chk({tag, "_data"}, out_data, 32'h0);
    chk({tag, "_count"}, out_count, 4'h0);
    chk({tag, "_last"}, out_last, 1'b0);
  endtask

  initial begin
    #1;
    chk_reset("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1) 4-bit packing
    push(8'h11, 0);
    push(8'h22, 0);
    push(8'h33, 0);
    push(8'h44, 0);
    chk_word("t1", 32'h44332211, 4'd4, 1'b0);
    tick();
    chk("t1_valid_fall", out_valid, 1'b0);

    // 2) 2-bit packing, upper nibbles ignored
    for (int i = 1; i <= 8; i++) push(8'hF0 | 8'(i), 1);
    chk_word("t2", 32'h87654321, 4'd8, 1'b0);
    tick();

    // 3) backpressure
    out_ready = 1'b0;
    push(8'h11, 0);
    push(8'h22, 0);
    push(8'h33, 0);
    push(8'h44, 0);
    chk_word("t3_w0", 32'h44332211, 4'd4, 1'b0);
    push(8'h55, 0);
    push(8'h66, 0);
    push(8'h77, 0);
    in_valid = 1'b1;
    in_data  = 8'h88;
    #1;
    chk("t3_stall_ready", in_ready, 1'b0);
    tick();
    tick();
    chk("t3_stall_ready2", in_ready, 1'b0);
    chk("t3_hold_data", out_data, 32'h44332211);
    chk("t3_hold_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    #1;
    chk("t3_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_word("t3_w1", 32'h88776655, 4'd4, 1'b0);
    tick();
    chk("t3_valid_fall", out_valid, 1'b0);

    // 4) flush of a partial word, then flush when empty
    push(8'hAB, 0);
    push(8'hCD, 0);
    pulse_flush();
    chk("t4_pend_ready", in_ready, 1'b0);
    wait_done();
    chk_word("t4", 32'h0000CDAB, 4'd2, 1'b1);
    tick();
    chk("t4_done_fall", flush_done, 1'b0);
    chk("t4_valid_fall", out_valid, 1'b0);
    pulse_flush();
    wait_done();
    chk("t4_empty_no_word", out_valid, 1'b0);
    tick();
    chk("t4_empty_done_fall", flush_done, 1'b0);

    // 5) mode switch
    push(8'h5A, 0);
    push(8'h03, 1);
    chk_word("t5_sw", 32'h0000005A, 4'd1, 1'b1);
    for (int i = 0; i < 7; i++) push(8'h03, 1);
    chk_word("t5_full", 32'h33333333, 4'd8, 1'b0);
    tick();

    // 6) reset mid-word, then clear coincident with an element
    push(8'h0A, 0);
    push(8'h0B, 0);
    rst_n = 1'b0;
    #1;
    chk_reset("t6_rst");
    tick();
    rst_n = 1'b1;
    tick();
    push(8'h01, 0);
    push(8'h02, 0);
    push(8'h03, 0);
    push(8'h04, 0);
    chk_word("t6_rst_word", 32'h04030201, 4'd4, 1'b0);
    tick();
    push(8'h0A, 0);
    push(8'h0B, 0);
    in_valid = 1'b1;
    in_data  = 8'h0C;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk_reset("t6_clr");
    push(8'h01, 0);
    push(8'h02, 0);
    push(8'h03, 0);
    push(8'h04, 0);
    chk_word("t6_clr_word", 32'h04030201, 4'd4, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
